// File: rtl/pe_win3x3_feeder_if.sv
// Pixel-stream and 3x3 window row ports between the feature-map source, the
// window feeder and the PE array.
interface pe_win3x3_feeder_if #(
  parameter int DW = 32
);
  logic            frame_start;
  logic            din_valid;
  logic [DW-1:0]   din;
  logic            win0_valid;
  logic            win1_valid;
  logic            win2_valid;
  logic [3*DW-1:0] win0_data3;
  logic [3*DW-1:0] win1_data3;
  logic [3*DW-1:0] win2_data3;
  logic            frame_done;

  modport master (
    output frame_start, din_valid, din,
    input  win0_valid, win1_valid, win2_valid,
    input  win0_data3, win1_data3, win2_data3, frame_done
  );

  modport slave (
    input  frame_start, din_valid, din,
    output win0_valid, win1_valid, win2_valid,
    output win0_data3, win1_data3, win2_data3, frame_done
  );
endinterface

// File: rtl/pe_win3x3_feeder.sv
// 3x3 window feeder for the PE array: two line buffers plus per-row taps, with
// row 1/2 staggered by PE_LAT. Define WIN_STRIDE2_EN for stride-2 windows.
module pe_win3x3_feeder #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int IMG_W    = 14,
  parameter int IMG_H    = 14,
  parameter int PE_LAT   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  pe_win3x3_feeder_if.slave  bus
);
  localparam int DW = 1 + EXPONENT + MANTISSA;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]   col, col_eff;
  logic [RW-1:0]   row, row_eff;
  logic            at_last, fire, frame_done_r;
  logic [DW-1:0]   lb0 [IMG_W];
  logic [DW-1:0]   lb1 [IMG_W];
  logic [DW-1:0]   up2, up1;
  logic [2*DW-1:0] sh0, sh1, sh2;

  logic            v0;
  logic [3*DW-1:0] d0;
  logic [PE_LAT:0]   v1;
  logic [3*DW-1:0]   d1 [PE_LAT+1];
  logic [2*PE_LAT:0] v2;
  logic [3*DW-1:0]   d2 [2*PE_LAT+1];

  // frame_start makes the concurrent pixel land at (0,0)
  assign col_eff = bus.frame_start ? '0 : col;
  assign row_eff = bus.frame_start ? '0 : row;
  assign up2     = lb0[col_eff];
  assign up1     = lb1[col_eff];
  assign at_last = (row == ROW_LAST) && (col == COL_LAST);

`ifdef WIN_STRIDE2_EN
  assign fire = bus.din_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2))
                && !row_eff[0] && !col_eff[0];
`else
  assign fire = bus.din_valid && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col          <= '0;
      row          <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= bus.din_valid && at_last;
      if (bus.din_valid) begin
        if (col_eff == COL_LAST) begin
          col <= '0;
          row <= (row_eff == ROW_LAST) ? '0 : row_eff + RW'(1);
        end else begin
          col <= col_eff + CW'(1);
          row <= row_eff;
        end
      end else if (bus.frame_start) begin
        col <= '0;
        row <= '0;
      end
    end
  end

  // Line buffers and column taps are not reset; windows only fire once the
  // current frame has refilled rows r-2..r.
  always_ff @(posedge clk) begin
    if (bus.din_valid) begin
      lb0[col_eff] <= up1;
      lb1[col_eff] <= bus.din;
      sh0          <= {sh0[DW-1:0], up2};
      sh1          <= {sh1[DW-1:0], up1};
      sh2          <= {sh2[DW-1:0], bus.din};
    end
  end

  // Each stage loads data only when its predecessor is valid, so outputs hold
  // between windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0;
      d0 <= '0;
      v1 <= '0;
      v2 <= '0;
      for (int i = 0; i <= PE_LAT; i++) d1[i] <= '0;
      for (int i = 0; i <= 2*PE_LAT; i++) d2[i] <= '0;
    end else begin
      v0    <= fire;
      v1[0] <= fire;
      v2[0] <= fire;
      if (fire) begin
        d0    <= {sh0, up2};
        d1[0] <= {sh1, up1};
        d2[0] <= {sh2, bus.din};
      end
      for (int i = 1; i <= PE_LAT; i++) begin
        v1[i] <= v1[i-1];
        if (v1[i-1]) d1[i] <= d1[i-1];
      end
      for (int i = 1; i <= 2*PE_LAT; i++) begin
        v2[i] <= v2[i-1];
        if (v2[i-1]) d2[i] <= d2[i-1];
      end
    end
  end

  assign bus.win0_valid = v0;
  assign bus.win0_data3 = d0;
  assign bus.win1_valid = v1[PE_LAT];
  assign bus.win1_data3 = d1[PE_LAT];
  assign bus.win2_valid = v2[2*PE_LAT];
  assign bus.win2_data3 = d2[2*PE_LAT];
  assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_pe_win3x3_feeder.sv
// Scoreboard bench for pe_win3x3_feeder: a frame-memory model predicts every
// window row, its arrival cycle and each frame_done pulse.
module tb_pe_win3x3_feeder;
  localparam int EXP    = 8;
  localparam int MAN    = 23;
  localparam int DW     = 1 + EXP + MAN;
  localparam int WW     = 3 * DW;
  localparam int PE_LAT = 2;
`ifdef WIN_STRIDE2_EN
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NWIN = ((H - 1) / 2) * ((W - 1) / 2);
`else
  localparam int W    = 4;
  localparam int H    = 4;
  localparam int NWIN = (H - 2) * (W - 2);
`endif
  localparam int DRAIN = 2 * PE_LAT + 4;

  typedef logic [WW-1:0] word_t;
  typedef struct {
    word_t data;
    int    t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pe_win3x3_feeder_if #(.DW(DW)) bus ();

  pe_win3x3_feeder #(
    .EXPONENT(EXP), .MANTISSA(MAN), .IMG_W(W), .IMG_H(H), .PE_LAT(PE_LAT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t q0[$], q1[$], q2[$];
  int   qd[$];
  int   tests = 0, fails = 0;
  int   w0_cnt = 0, fd_cnt = 0;
  word_t first_w0 = '0;
  logic [DW-1:0] mem [H][W];
  int   m_r = 0, m_c = 0;

  task automatic chk(input string tag, input word_t got, input word_t want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic word_t wrow(input int r, input int c);
    return {mem[r][c-2], mem[r][c-1], mem[r][c]};
  endfunction

  function automatic bit fire_f(input int r, input int c);
`ifdef WIN_STRIDE2_EN
    return (r >= 2) && (c >= 2) && (r % 2 == 0) && (c % 2 == 0);
`else
    return (r >= 2) && (c >= 2);
`endif
  endfunction

  task automatic pop_chk(input int k, input word_t d);
    exp_t e;
    int   n;
    n = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
    chk($sformatf("win%0d_expected", k), word_t'(n > 0), word_t'(1));
    if (n > 0) begin
      if (k == 0) e = q0.pop_front();
      else if (k == 1) e = q1.pop_front();
      else e = q2.pop_front();
      chk($sformatf("win%0d_data", k), d, e.data);
      chk($sformatf("win%0d_cycle", k), word_t'(cyc), word_t'(e.t));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.win0_valid) begin
        w0_cnt++;
        if (w0_cnt == 1) first_w0 = bus.win0_data3;
        pop_chk(0, bus.win0_data3);
      end
      if (bus.win1_valid) pop_chk(1, bus.win1_data3);
      if (bus.win2_valid) pop_chk(2, bus.win2_data3);
      if (bus.frame_done) begin
        fd_cnt++;
        chk("frame_done_expected", word_t'(qd.size() > 0), word_t'(1));
        if (qd.size() > 0) chk("frame_done_cycle", word_t'(cyc), word_t'(qd.pop_front()));
      end
    end
  end

  task automatic send(input int p, input logic fs);
    bit last;
    @(negedge clk);
    bus.din_valid   = 1'b1;
    bus.din         = DW'(p);
    bus.frame_start = fs;
    last = (m_r == H - 1) && (m_c == W - 1);
    if (fs) begin
      m_r = 0;
      m_c = 0;
    end
    mem[m_r][m_c] = DW'(p);
    if (fire_f(m_r, m_c)) begin
      q0.push_back('{wrow(m_r - 2, m_c), cyc + 1});
      q1.push_back('{wrow(m_r - 1, m_c), cyc + 1 + PE_LAT});
      q2.push_back('{wrow(m_r, m_c), cyc + 1 + 2 * PE_LAT});
    end
    if (last) qd.push_back(cyc + 1);
    if (m_c == W - 1) begin
      m_c = 0;
      m_r = (m_r == H - 1) ? 0 : m_r + 1;
    end else begin
      m_c++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.din_valid   = 1'b0;
      bus.frame_start = 1'b0;
    end
  endtask

  task automatic chk_counts(input string tag, input int nwin, input int nfd);
    chk({tag, "_windows"}, word_t'(w0_cnt), word_t'(nwin));
    chk({tag, "_frame_done"}, word_t'(fd_cnt), word_t'(nfd));
    chk({tag, "_drained"}, word_t'(q0.size() + q1.size() + q2.size() + qd.size()), word_t'(0));
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.din_valid   = 1'b0;
    bus.din         = '0;
    repeat (2) @(negedge clk);
    chk("rst_win0_valid", word_t'(bus.win0_valid), word_t'(0));
    chk("rst_win1_valid", word_t'(bus.win1_valid), word_t'(0));
    chk("rst_win2_valid", word_t'(bus.win2_valid), word_t'(0));
    chk("rst_frame_done", word_t'(bus.frame_done), word_t'(0));
    chk("rst_win2_data", bus.win2_data3, word_t'(0));
    #1 rst_n = 1'b1;

    // contiguous frame, p(i)=i
    w0_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < W * H; i++) send(i, 1'b0);
    idle(DRAIN);
    chk_counts("contig", NWIN, 1);
    chk("first_window", first_w0, {DW'(0), DW'(1), DW'(2)});

    // gapped frame
    w0_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < W * H; i++) begin
      send(1000 + i, 1'b0);
      idle(1);
    end
    idle(DRAIN);
    chk_counts("gapped", NWIN, 1);

    // two frames back to back
    w0_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 2 * W * H; i++) send(2000 + i, 1'b0);
    idle(DRAIN);
    chk_counts("b2b", 2 * NWIN, 2);

    // reset after pixel 11, in-flight windows discarded
    for (int i = 0; i < 12; i++) send(3000 + i, 1'b0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.din_valid = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); qd.delete();
    m_r = 0; m_c = 0;
    @(negedge clk);
    chk("midrst_win0_valid", word_t'(bus.win0_valid), word_t'(0));
    chk("midrst_win1_valid", word_t'(bus.win1_valid), word_t'(0));
    chk("midrst_win2_valid", word_t'(bus.win2_valid), word_t'(0));
    #1 rst_n = 1'b1;
    w0_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < W * H; i++) send(4000 + i, 1'b0);
    idle(DRAIN);
    chk_counts("after_rst", NWIN, 1);

    // frame_start with the 8th pixel of a frame
    for (int i = 0; i < 7; i++) send(5000 + i, 1'b0);
    w0_cnt = 0; fd_cnt = 0;
    send(6000, 1'b1);
    for (int i = 1; i < W * H; i++) send(6000 + i, 1'b0);
    idle(DRAIN);
    chk_counts("frame_start", NWIN, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
